// File: rtl/syn_fifo_pkg.sv
`default_nettype none
// ============================================================================
// Module  : syn_fifo_pkg
// Purpose : Shared sizing helpers and parameter checks for syn_fifo_param.
// Rev     : 1.0  initial release
// ============================================================================
package syn_fifo_pkg;

    function automatic int unsigned fifo_depth(input int unsigned addr_width);
        return 32'd1 << addr_width;
    endfunction

    // Occupancy needs one extra bit so that DEPTH itself is representable.
    function automatic int unsigned count_width(input int unsigned addr_width);
        return addr_width + 32'd1;
    endfunction

    function automatic bit thresh_legal(input int unsigned addr_width,
                                        input int unsigned afull_thresh,
                                        input int unsigned aempty_thresh);
        return (addr_width >= 32'd2) &&
               (afull_thresh >= 32'd1) &&
               (afull_thresh <= fifo_depth(addr_width)) &&
               (aempty_thresh <= fifo_depth(addr_width) - 32'd1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/syn_fifo_mem.sv
`default_nettype none
// ============================================================================
// Module  : syn_fifo_mem
// Purpose : FIFO storage, one synchronous write port, one asynchronous read.
// Rev     : 1.0  initial release
// ============================================================================
module syn_fifo_mem
    import syn_fifo_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned ADDR_WIDTH = 4
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] waddr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic [ADDR_WIDTH-1:0] raddr,
    output logic [DATA_WIDTH-1:0] rdata
);

    localparam int unsigned C_DEPTH = fifo_depth(ADDR_WIDTH);

    logic [DATA_WIDTH-1:0] r_mem [C_DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            r_mem[waddr] <= wdata;
        end
    end

    assign rdata = r_mem[raddr];

endmodule
`default_nettype wire

// File: rtl/syn_fifo_param.sv
`default_nettype none
// ============================================================================
// Module  : syn_fifo_param
// Purpose : Single-clock FIFO with occupancy count, programmable thresholds
//           and sticky overflow/underflow. Define SYN_FIFO_FWFT_EN for
//           first-word-fall-through reads.
// Rev     : 1.0  initial release
// ============================================================================
module syn_fifo_param
    import syn_fifo_pkg::*;
#(
    parameter int unsigned DATA_WIDTH    = 8,
    parameter int unsigned ADDR_WIDTH    = 4,
    parameter int unsigned AFULL_THRESH  = fifo_depth(ADDR_WIDTH) - 2,
    parameter int unsigned AEMPTY_THRESH = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr_en,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  rd_en,
    input  logic                  err_clr,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  data_valid,
    output logic                  full,
    output logic                  empty,
    output logic                  almost_full,
    output logic                  almost_empty,
    output logic [ADDR_WIDTH:0]   count,
    output logic                  overflow,
    output logic                  underflow
);

    typedef logic [count_width(ADDR_WIDTH)-1:0] count_t;

    localparam count_t C_DEPTH  = count_t'(fifo_depth(ADDR_WIDTH));
    localparam count_t C_AFULL  = count_t'(AFULL_THRESH);
    localparam count_t C_AEMPTY = count_t'(AEMPTY_THRESH);
    localparam count_t C_ONE    = count_t'(1);

    if (!thresh_legal(ADDR_WIDTH, AFULL_THRESH, AEMPTY_THRESH)) begin : g_thresh_check
        $error("syn_fifo_param: illegal ADDR_WIDTH or threshold parameters");
    end

    logic [ADDR_WIDTH-1:0] r_wr_ptr;
    logic [ADDR_WIDTH-1:0] r_rd_ptr;
    count_t                r_count;
    logic                  r_overflow;
    logic                  r_underflow;

    logic                  w_full;
    logic                  w_empty;
    logic                  w_wr_acc;
    logic                  w_rd_acc;
    logic                  w_mem_we;
    logic [DATA_WIDTH-1:0] w_rd_data;

    assign w_full   = (r_count == C_DEPTH);
    assign w_empty  = (r_count == '0);
    assign w_wr_acc = wr_en & ~w_full;
    assign w_rd_acc = rd_en & ~w_empty;
    // Nothing is accepted while reset is asserted, including the array write.
    assign w_mem_we = w_wr_acc & ~rst;

    syn_fifo_mem #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_mem (
        .clk   (clk),
        .we    (w_mem_we),
        .waddr (r_wr_ptr),
        .wdata (data_in),
        .raddr (r_rd_ptr),
        .rdata (w_rd_data)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            if (w_wr_acc) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_rd_acc) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            if (w_wr_acc && !w_rd_acc) begin
                r_count <= r_count + C_ONE;
            end else if (w_rd_acc && !w_wr_acc) begin
                r_count <= r_count - C_ONE;
            end
            // A new error in the same cycle as err_clr must survive the clear.
            r_overflow  <= (wr_en & w_full)  | (r_overflow  & ~err_clr);
            r_underflow <= (rd_en & w_empty) | (r_underflow & ~err_clr);
        end
    end

`ifdef SYN_FIFO_FWFT_EN
    assign data_out   = w_rd_data;
    assign data_valid = ~w_empty;
`else
    logic [DATA_WIDTH-1:0] r_data_out;
    logic                  r_data_valid;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_data_out   <= '0;
            r_data_valid <= 1'b0;
        end else begin
            r_data_valid <= w_rd_acc;
            if (w_rd_acc) begin
                r_data_out <= w_rd_data;
            end
        end
    end

    assign data_out   = r_data_out;
    assign data_valid = r_data_valid;
`endif

    assign full         = w_full;
    assign empty        = w_empty;
    assign almost_full  = (r_count >= C_AFULL);
    assign almost_empty = (r_count <= C_AEMPTY);
    assign count        = r_count;
    assign overflow     = r_overflow;
    assign underflow    = r_underflow;

endmodule
`default_nettype wire

// File: tb/tb_syn_fifo_param.sv
`default_nettype none
// ============================================================================
// Module  : tb_syn_fifo_param
// Purpose : Self-checking bench for syn_fifo_param (DEPTH 8, thresholds 6/2).
// Rev     : 1.0  initial release
// ============================================================================
module tb_syn_fifo_param;

    localparam int DW    = 8;
    localparam int AW    = 3;
    localparam int DEPTH = 8;
    localparam int AFT   = 6;
    localparam int AET   = 2;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          wr_en = 1'b0;
    logic [DW-1:0] data_in = '0;
    logic          rd_en = 1'b0;
    logic          err_clr = 1'b0;
    logic [DW-1:0] data_out;
    logic          data_valid;
    logic          full;
    logic          empty;
    logic          almost_full;
    logic          almost_empty;
    logic [AW:0]   count;
    logic          overflow;
    logic          underflow;

    syn_fifo_param #(
        .DATA_WIDTH    (DW),
        .ADDR_WIDTH    (AW),
        .AFULL_THRESH  (AFT),
        .AEMPTY_THRESH (AET)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .wr_en        (wr_en),
        .data_in      (data_in),
        .rd_en        (rd_en),
        .err_clr      (err_clr),
        .data_out     (data_out),
        .data_valid   (data_valid),
        .full         (full),
        .empty        (empty),
        .almost_full  (almost_full),
        .almost_empty (almost_empty),
        .count        (count),
        .overflow     (overflow),
        .underflow    (underflow)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic          w;
        logic          r;
        logic          c;
        logic [DW-1:0] d;
        int            ecnt;
        logic          eovf;
        logic          eunf;
        logic          edv;
    } vec_t;

    vec_t          tbl[26];
    logic [DW-1:0] sb[$];
    int            n_vec = 0;
    int            n_err = 0;

    // Reference state, advanced from the stimulus alone.
    int            m_count = 0;
    logic          m_ovf = 1'b0;
    logic          m_unf = 1'b0;
    logic          m_dv = 1'b0;

    task automatic chk(input string name, input int act, input int exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic chk_state(input string tag, input int ecnt, input logic eovf,
                             input logic eunf, input logic edv);
        chk({tag, ".count"},        int'(count),        ecnt);
        chk({tag, ".full"},         int'(full),         int'(ecnt == DEPTH));
        chk({tag, ".empty"},        int'(empty),        int'(ecnt == 0));
        chk({tag, ".almost_full"},  int'(almost_full),  int'(ecnt >= AFT));
        chk({tag, ".almost_empty"}, int'(almost_empty), int'(ecnt <= AET));
        chk({tag, ".overflow"},     int'(overflow),     int'(eovf));
        chk({tag, ".underflow"},    int'(underflow),    int'(eunf));
        chk({tag, ".data_valid"},   int'(data_valid),   int'(edv));
    endtask

    // One clock: drive, update the model and scoreboard, then sample #1 after the edge.
    task automatic step(input logic w, input logic r, input logic c, input logic x,
                        input logic [DW-1:0] d);
        logic wa;
        logic ra;
        logic [DW-1:0] exp_d;
        wr_en = w; rd_en = r; err_clr = c; rst = x; data_in = d;
        wa = w && (m_count != DEPTH);
        ra = r && (m_count != 0);
        exp_d = '0;
        if (!x && ra) exp_d = sb.pop_front();
        if (!x && wa) sb.push_back(d);
`ifdef SYN_FIFO_FWFT_EN
        #1;
        if (!x && ra) chk("fwft_head", int'(data_out), int'(exp_d));
`endif
        @(posedge clk);
        #1;
        wr_en = 1'b0; rd_en = 1'b0; err_clr = 1'b0; rst = 1'b0;
        if (x) begin
            m_count = 0; m_ovf = 1'b0; m_unf = 1'b0; m_dv = 1'b0;
            sb.delete();
        end else begin
            m_ovf = (w && m_count == DEPTH) || (m_ovf && !c);
            m_unf = (r && m_count == 0) || (m_unf && !c);
            m_count = m_count + int'(wa) - int'(ra);
`ifdef SYN_FIFO_FWFT_EN
            m_dv = (m_count != 0);
`else
            m_dv = ra;
            if (ra) chk("rd_data", int'(data_out), int'(exp_d));
`endif
        end
    endtask

    initial begin
        // Fill, overflow, read-with-dropped-write, drain, underflow and clear.
        for (int i = 0; i < 8; i++) tbl[i] = '{1'b1, 1'b0, 1'b0, 8'(8'h10 + i), i + 1, 1'b0, 1'b0, 1'b0};
        tbl[8]  = '{1'b1, 1'b0, 1'b0, 8'hAA, 8, 1'b1, 1'b0, 1'b0};
        tbl[9]  = '{1'b0, 1'b0, 1'b0, 8'h00, 8, 1'b1, 1'b0, 1'b0};
        tbl[10] = '{1'b0, 1'b0, 1'b1, 8'h00, 8, 1'b0, 1'b0, 1'b0};
        tbl[11] = '{1'b1, 1'b1, 1'b0, 8'hBB, 7, 1'b1, 1'b0, 1'b1};
        tbl[12] = '{1'b0, 1'b0, 1'b1, 8'h00, 7, 1'b0, 1'b0, 1'b0};
        for (int i = 0; i < 7; i++) tbl[13 + i] = '{1'b0, 1'b1, 1'b0, 8'h00, 6 - i, 1'b0, 1'b0, 1'b1};
        tbl[20] = '{1'b0, 1'b1, 1'b0, 8'h00, 0, 1'b0, 1'b1, 1'b0};
        tbl[21] = '{1'b0, 1'b0, 1'b0, 8'h00, 0, 1'b0, 1'b1, 1'b0};
        tbl[22] = '{1'b0, 1'b0, 1'b1, 8'h00, 0, 1'b0, 1'b0, 1'b0};
        tbl[23] = '{1'b0, 1'b1, 1'b1, 8'h00, 0, 1'b0, 1'b1, 1'b0};
        tbl[24] = '{1'b0, 1'b0, 1'b1, 8'h00, 0, 1'b0, 1'b0, 1'b0};
        tbl[25] = '{1'b0, 1'b0, 1'b0, 8'h00, 0, 1'b0, 1'b0, 1'b0};

        step(1'b0, 1'b0, 1'b0, 1'b1, 8'h00);
        chk_state("reset", 0, 1'b0, 1'b0, 1'b0);
`ifndef SYN_FIFO_FWFT_EN
        chk("reset.data_out", int'(data_out), 0);
`endif

        for (int i = 0; i < 26; i++) begin
            logic edv;
            step(tbl[i].w, tbl[i].r, tbl[i].c, 1'b0, tbl[i].d);
`ifdef SYN_FIFO_FWFT_EN
            edv = (tbl[i].ecnt != 0);
`else
            edv = tbl[i].edv;
`endif
            chk_state($sformatf("vec%0d", i), tbl[i].ecnt, tbl[i].eovf, tbl[i].eunf, edv);
        end

        // Hold occupancy at 3 under simultaneous traffic; pointers wrap twice.
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b0, 1'b0, 8'(8'h30 + i));
        for (int i = 0; i < 20; i++) begin
            step(1'b1, 1'b1, 1'b0, 1'b0, 8'(8'h40 + i));
            chk_state($sformatf("wrap%0d", i), 3, 1'b0, 1'b0, m_dv);
        end
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
        chk_state("wrap_drained", 0, 1'b0, 1'b0, m_dv);

        // Reset at occupancy 5 with a write pending in the reset cycle.
        for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 1'b0, 1'b0, 8'(8'h60 + i));
        chk_state("pre_rst", 5, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0, 1'b1, 8'hEE);
        chk_state("mid_rst", 0, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0, 1'b0, 8'h77);
        chk_state("post_rst_wr", 1, 1'b0, 1'b0, m_dv);
        step(1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
        chk_state("post_rst_rd", 0, 1'b0, 1'b0, m_dv);

        // First word after a write into an empty FIFO.
        step(1'b1, 1'b0, 1'b0, 1'b0, 8'h5C);
`ifdef SYN_FIFO_FWFT_EN
        chk("fwft_first.data_out", int'(data_out), 32'h5C);
        chk("fwft_first.data_valid", int'(data_valid), 1);
`endif
        step(1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
        chk_state("last_pop", 0, 1'b0, 1'b0, m_dv);
        chk("sb_left", sb.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
